// File: rtl/rob_multi_wb_if.sv
// rob_multi_wb_if: decoder/RS/LSB/regfile/ifetch-facing bus of the reorder buffer
interface rob_multi_wb_if #(parameter int IDX_W = 4, parameter int NUM_WB = 3, parameter int OP_W = 6);
  logic alloc_valid;
  logic [OP_W-1:0] alloc_op;
  logic [4:0] alloc_rd;
  logic [31:0] alloc_pc;
  logic [31:0] alloc_imm;
  logic alloc_pred;
  logic alloc_ready;
  logic [IDX_W-1:0] alloc_id;
  logic [IDX_W-1:0] q1_id;
  logic [IDX_W-1:0] q2_id;
  logic q1_ready;
  logic q2_ready;
  logic [31:0] q1_value;
  logic [31:0] q2_value;
  logic [NUM_WB-1:0] wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_id;
  logic [NUM_WB*32-1:0] wb_value;
  logic [IDX_W-1:0] head_id;
  logic [IDX_W:0] count;
  logic commit_valid;
  logic [4:0] commit_rd;
  logic [IDX_W-1:0] commit_id;
  logic [31:0] commit_value;
  logic br_valid;
  logic [31:0] br_pc;
  logic br_pred;
  logic br_taken;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic flush;
  logic halt;
  modport master (
    output alloc_valid, alloc_op, alloc_rd, alloc_pc, alloc_imm, alloc_pred, q1_id, q2_id,
           wb_valid, wb_id, wb_value,
    input  alloc_ready, alloc_id, q1_ready, q2_ready, q1_value, q2_value, head_id, count,
           commit_valid, commit_rd, commit_id, commit_value, br_valid, br_pc, br_pred, br_taken,
           redirect_valid, redirect_pc, flush, halt
  );
  modport slave (
    input  alloc_valid, alloc_op, alloc_rd, alloc_pc, alloc_imm, alloc_pred, q1_id, q2_id,
           wb_valid, wb_id, wb_value,
    output alloc_ready, alloc_id, q1_ready, q2_ready, q1_value, q2_value, head_id, count,
           commit_valid, commit_rd, commit_id, commit_value, br_valid, br_pc, br_pred, br_taken,
           redirect_valid, redirect_pc, flush, halt
  );
endinterface

// File: rtl/rob_multi_wb.sv
// rob_multi_wb: in-order-retire reorder buffer with multiple writeback channels and commit-time branch resolution
module rob_multi_wb #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int NUM_WB = 3,
  parameter int OP_W   = 6
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  rob_multi_wb_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ISSUED, DONE} ent_t;
  ent_t st [DEPTH];
  logic [OP_W-1:0] op [DEPTH];
  logic [4:0] rd [DEPTH];
  logic [31:0] pc [DEPTH];
  logic [31:0] imm [DEPTH];
  logic [31:0] val [DEPTH];
  logic pred [DEPTH];
  logic [IDX_W-1:0] head, tail;
  logic [IDX_W:0] cnt;
  logic [IDX_W-1:0] wid [NUM_WB];
  logic [31:0] wval [NUM_WB];
  logic [NUM_WB-1:0] hit;
  logic full, head_done, is_br, is_jalr, is_exit, mispred, do_commit, alloc_ok;
  logic [31:0] br_target;
  // a writeback only lands on an ISSUED entry, so it can never collide with the committing head or the allocating tail
  always_comb begin
    for (int k = 0; k < NUM_WB; k++) begin
      wid[k] = bus.wb_id[k*IDX_W +: IDX_W];
      wval[k] = bus.wb_value[k*32 +: 32];
      hit[k] = bus.wb_valid[k] && st[wid[k]] == ISSUED;
    end
  end
  function automatic logic [32:0] lookup(input logic [IDX_W-1:0] id);
    lookup = st[id] == DONE ? {1'b1, val[id]} : 33'd0;
    for (int k = 0; k < NUM_WB; k++)
      if (hit[k] && wid[k] == id) lookup = {1'b1, wval[k]};
  endfunction
  always_comb begin
    {bus.q1_ready, bus.q1_value} = lookup(bus.q1_id);
    {bus.q2_ready, bus.q2_value} = lookup(bus.q2_id);
  end
  assign full = cnt == (IDX_W+1)'(DEPTH);
  assign head_done = st[head] == DONE && !bus.halt;
  assign is_br = op[head] >= OP_W'(4) && op[head] <= OP_W'(7);
  assign is_jalr = op[head] == OP_W'(3);
  assign is_exit = op[head] == OP_W'(39);
  assign mispred = head_done && is_br && (val[head][0] != pred[head]);
  assign do_commit = head_done && !mispred;
  assign alloc_ok = bus.alloc_valid && !full && !mispred;
  assign br_target = pc[head] + (val[head][0] ? imm[head] : 32'd4);
  assign bus.alloc_ready = !full;
  assign bus.alloc_id = tail;
  assign bus.head_id = head;
  assign bus.count = cnt;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) st[i] <= EMPTY;
      bus.commit_valid <= 1'b0;
      bus.commit_rd <= '0;
      bus.commit_id <= '0;
      bus.commit_value <= '0;
      bus.br_valid <= 1'b0;
      bus.br_pc <= '0;
      bus.br_pred <= 1'b0;
      bus.br_taken <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc <= '0;
      bus.flush <= 1'b0;
      bus.halt <= 1'b0;
    end else if (rdy_in) begin
      bus.commit_valid <= do_commit;
      bus.br_valid <= head_done && is_br;
      bus.redirect_valid <= mispred || (do_commit && is_jalr);
      bus.flush <= mispred;
      bus.halt <= bus.halt || (do_commit && is_exit);
      if (do_commit) begin
        bus.commit_rd <= rd[head];
        bus.commit_id <= head;
        bus.commit_value <= val[head];
      end
      if (head_done && is_br) begin
        bus.br_pc <= pc[head];
        bus.br_pred <= pred[head];
        bus.br_taken <= val[head][0];
      end
      if (mispred || (do_commit && is_jalr)) bus.redirect_pc <= mispred ? br_target : val[head];
      if (mispred) begin
        head <= '0;
        tail <= '0;
        cnt <= '0;
        for (int i = 0; i < DEPTH; i++) st[i] <= EMPTY;
      end else begin
        for (int k = 0; k < NUM_WB; k++)
          if (hit[k]) begin
            st[wid[k]] <= DONE;
            val[wid[k]] <= wval[k];
          end
        if (do_commit) begin
          st[head] <= EMPTY;
          head <= head + 1'b1;
        end
        if (alloc_ok) begin
          st[tail] <= ISSUED;
          op[tail] <= bus.alloc_op;
          rd[tail] <= bus.alloc_rd;
          pc[tail] <= bus.alloc_pc;
          imm[tail] <= bus.alloc_imm;
          pred[tail] <= bus.alloc_pred;
          tail <= tail + 1'b1;
        end
        cnt <= cnt + (IDX_W+1)'(alloc_ok) - (IDX_W+1)'(do_commit);
      end
    end
  end
endmodule
